// File: rtl/fwd_pkg.sv
// Shared types and helpers for the forwarding / hazard unit.
// The entry struct stores rd zero-extended to FWD_MAX_AW bits, so any
// register-index width up to FWD_MAX_AW fits the same type.
package fwd_pkg;

  localparam int FWD_MAX_AW = 8;

  // Select value meaning "take the operand from the register file".
  localparam int FWD_SEL_RF = 0;

  typedef struct packed {
    logic                  valid;
    logic                  regwrite;
    logic                  is_load;
    logic [FWD_MAX_AW-1:0] rd;
  } fwdEntry_t;

  // Ceiling log2, used at elaboration time for select widths.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fwd_src_match.sv
// Per-operand matcher: priority-encodes the shadow-pipeline stages for the
// operand currently in EX (forwarding select) and for the operand waiting in
// ID (load-use stall request). Index 0 is the youngest stage in both cases.
module fwd_src_match
  import fwd_pkg::*;
#(
  parameter int FWD_DEPTH  = 2,
  parameter int REG_AW     = 5,
  parameter int LOAD_READY = 2,
  parameter int SELW       = 2
) (
  input  fwdEntry_t          entries [FWD_DEPTH+1],
  input  logic [REG_AW-1:0]  exSrc,
  input  logic               exUsed,
  input  logic [REG_AW-1:0]  idSrc,
  input  logic               idUsed,
  output logic [SELW-1:0]    fwdSel,
  output logic               stallReq
);

  // EX operands forward from post-EX stages only; ID operands look at every
  // stage that will still be forwardable-or-pending one cycle from now.
  logic [FWD_DEPTH:1]   exHit;
  logic [FWD_DEPTH-1:0] idHit;

  genvar gi;
  generate
    for (gi = 1; gi <= FWD_DEPTH; gi++) begin : g_ex_hit
      assign exHit[gi] = exUsed & entries[gi].valid & entries[gi].regwrite &
                         (entries[gi].rd != '0) &
                         (entries[gi].rd == FWD_MAX_AW'(exSrc));
    end
    for (gi = 0; gi < FWD_DEPTH; gi++) begin : g_id_hit
      assign idHit[gi] = idUsed & entries[gi].valid & entries[gi].regwrite &
                         (entries[gi].rd != '0) &
                         (entries[gi].rd == FWD_MAX_AW'(idSrc));
    end
  endgenerate

  // Smallest usable stage wins; scanning oldest-first lets the youngest overwrite.
  always_comb begin
    fwdSel = SELW'(FWD_SEL_RF);
    for (int k = FWD_DEPTH; k >= 1; k--) begin
      if (exHit[k] && (!entries[k].is_load || k >= LOAD_READY)) begin
        fwdSel = SELW'(k);
      end
    end
  end

  // The youngest matching producer decides; stall only if it is a load whose
  // data will still be out of reach after it advances one stage.
  always_comb begin
    stallReq = 1'b0;
    for (int s = FWD_DEPTH - 1; s >= 0; s--) begin
      if (idHit[s]) begin
        stallReq = entries[s].is_load && (s + 1 < LOAD_READY);
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit. Keeps a shadow copy of the register
// writers in EX and the FWD_DEPTH stages after it, drives the EX operand
// mux selects and the ID/IF hold.
// Optional statistics counters: define FWD_HAZARD_STATS_EN.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter  int NUM_SRC    = 2,
  parameter  int FWD_DEPTH  = 2,
  parameter  int REG_AW     = 5,
  parameter  int LOAD_READY = 2,
  localparam int SELW       = clog2(FWD_DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      pipe_hold,
  input  logic                      flush,
  input  logic                      id_valid,
  input  logic                      id_regwrite,
  input  logic                      id_is_load,
  input  logic [REG_AW-1:0]         id_rd,
  input  logic [NUM_SRC*REG_AW-1:0] id_src,
  input  logic [NUM_SRC-1:0]        id_src_used,
  output logic                      stall,
  output logic [NUM_SRC*SELW-1:0]   ex_fwd_sel
`ifdef FWD_HAZARD_STATS_EN
  ,
  output logic [31:0]               stat_stall_cnt,
  output logic [31:0]               stat_fwd_cnt
`endif
);

  fwdEntry_t                 entryReg  [FWD_DEPTH+1];
  fwdEntry_t                 entryNext [FWD_DEPTH+1];
  logic [NUM_SRC*REG_AW-1:0] exSrcReg, exSrcNext;
  logic [NUM_SRC-1:0]        exUsedReg, exUsedNext;
  logic [NUM_SRC-1:0]        stallReqVec;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      fwd_src_match #(
        .FWD_DEPTH  (FWD_DEPTH),
        .REG_AW     (REG_AW),
        .LOAD_READY (LOAD_READY),
        .SELW       (SELW)
      ) u_match (
        .entries  (entryReg),
        .exSrc    (exSrcReg[gi*REG_AW +: REG_AW]),
        .exUsed   (exUsedReg[gi]),
        .idSrc    (id_src[gi*REG_AW +: REG_AW]),
        .idUsed   (id_src_used[gi]),
        .fwdSel   (ex_fwd_sel[gi*SELW +: SELW]),
        .stallReq (stallReqVec[gi])
      );
    end
  endgenerate

  // A redirect kills the ID instruction, so it can never cause a hold.
  assign stall = id_valid & ~flush & (|stallReqVec);

  // Next shadow-pipeline contents: shift, insert ID (or a bubble), apply flush.
  always_comb begin
    for (int k = 0; k < FWD_DEPTH; k++) begin
      entryNext[k+1] = entryReg[k];
    end
    entryNext[0].valid    = id_valid;
    entryNext[0].regwrite = id_valid & id_regwrite;
    entryNext[0].is_load  = id_valid & id_is_load;
    entryNext[0].rd       = FWD_MAX_AW'(id_rd);
    exSrcNext             = id_src;
    exUsedNext            = id_src_used;
    // The instruction leaving EX is on the wrong path too.
    if (flush) begin
      entryNext[1] = '0;
    end
    if (flush || stall) begin
      entryNext[0] = '0;
      exUsedNext   = '0;
    end
  end

  // State register; a pipeline freeze holds everything in place.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k <= FWD_DEPTH; k++) begin
        entryReg[k] <= '0;
      end
      exSrcReg  <= '0;
      exUsedReg <= '0;
    end else if (!pipe_hold) begin
      entryReg  <= entryNext;
      exSrcReg  <= exSrcNext;
      exUsedReg <= exUsedNext;
    end
  end

`ifdef FWD_HAZARD_STATS_EN
  logic [31:0] stallCntReg;
  logic [31:0] fwdCntReg;
  logic [31:0] fwdOpsNow;
  logic [32:0] fwdSum;

  // Number of EX operands taking a forwarded value this cycle.
  always_comb begin
    fwdOpsNow = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (ex_fwd_sel[i*SELW +: SELW] != SELW'(FWD_SEL_RF)) begin
        fwdOpsNow = fwdOpsNow + 32'd1;
      end
    end
  end

  assign fwdSum = {1'b0, fwdCntReg} + {1'b0, fwdOpsNow};

  // Saturating event counters, advanced only on non-held cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stallCntReg <= '0;
      fwdCntReg   <= '0;
    end else if (!pipe_hold) begin
      if (stall && (stallCntReg != '1)) begin
        stallCntReg <= stallCntReg + 32'd1;
      end
      fwdCntReg <= fwdSum[32] ? '1 : fwdSum[31:0];
    end
  end

  assign stat_stall_cnt = stallCntReg;
  assign stat_fwd_cnt   = fwdCntReg;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboarded bench for fwd_hazard_unit (default parameters).
module tb_fwd_hazard_unit;

  localparam int NUM_SRC = 2;
  localparam int REG_AW  = 5;
  localparam int SELW    = 2;

  logic                      clk         = 1'b0;
  logic                      rst         = 1'b1;
  logic                      pipe_hold   = 1'b0;
  logic                      flush       = 1'b0;
  logic                      id_valid    = 1'b0;
  logic                      id_regwrite = 1'b0;
  logic                      id_is_load  = 1'b0;
  logic [REG_AW-1:0]         id_rd       = '0;
  logic [NUM_SRC*REG_AW-1:0] id_src      = '0;
  logic [NUM_SRC-1:0]        id_src_used = '0;
  logic                      stall;
  logic [NUM_SRC*SELW-1:0]   ex_fwd_sel;
`ifdef FWD_HAZARD_STATS_EN
  logic [31:0]               stat_stall_cnt;
  logic [31:0]               stat_fwd_cnt;
`endif

  int nAsserts = 0;
  int nFails   = 0;

  typedef struct {
    string      tag;
    logic       st;
    logic [1:0] s0;
    logic [1:0] s1;
  } exp_t;

  exp_t sbq[$];

  always #5 clk = ~clk;

  fwd_hazard_unit dut (
    .clk         (clk),
    .rst         (rst),
    .pipe_hold   (pipe_hold),
    .flush       (flush),
    .id_valid    (id_valid),
    .id_regwrite (id_regwrite),
    .id_is_load  (id_is_load),
    .id_rd       (id_rd),
    .id_src      (id_src),
    .id_src_used (id_src_used),
    .stall       (stall),
    .ex_fwd_sel  (ex_fwd_sel)
`ifdef FWD_HAZARD_STATS_EN
    ,
    .stat_stall_cnt (stat_stall_cnt),
    .stat_fwd_cnt   (stat_fwd_cnt)
`endif
  );

  task automatic set_id(input logic v, input logic rw, input logic ld,
                        input logic [4:0] rd, input logic [4:0] s0,
                        input logic [4:0] s1, input logic [1:0] used);
    id_valid    = v;
    id_regwrite = rw;
    id_is_load  = ld;
    id_rd       = rd;
    id_src      = {s1, s0};
    id_src_used = used;
  endtask

  task automatic sb_push(input string tag, input logic st,
                         input logic [1:0] s0, input logic [1:0] s1);
    exp_t e;
    e.tag = tag;
    e.st  = st;
    e.s0  = s0;
    e.s1  = s1;
    sbq.push_back(e);
  endtask

  task automatic drain();
    flush     = 1'b0;
    pipe_hold = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 2'b00);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    set_id(1, 1, 1, 5'd5, 5'd5, 5'd5, 2'b11);
    for (int c = 0; c < 3; c++) begin
      if (c == 2) begin
        rst = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 2'b00);
      end
      sb_push($sformatf("reset c%0d", c), 1'b0, 2'd0, 2'd0);
      @(negedge clk);
      e = sbq.pop_front();
      $display("[%0t] %s: stall=%b sel0=%0d sel1=%0d", $time, e.tag, stall, ex_fwd_sel[1:0], ex_fwd_sel[3:2]);
      nAsserts++;
      if (stall !== e.st) begin nFails++; $display("FAIL %s stall: got %b expected %b", e.tag, stall, e.st); end
      nAsserts++;
      if (ex_fwd_sel[1:0] !== e.s0) begin nFails++; $display("FAIL %s sel0: got %0d expected %0d", e.tag, ex_fwd_sel[1:0], e.s0); end
      nAsserts++;
      if (ex_fwd_sel[3:2] !== e.s1) begin nFails++; $display("FAIL %s sel1: got %0d expected %0d", e.tag, ex_fwd_sel[3:2], e.s1); end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_alu_fwd();
    exp_t e;
    for (int c = 0; c < 5; c++) begin
      case (c)
        0: begin set_id(1, 1, 0, 5'd3, 5'd0, 5'd0, 2'b00); sb_push("alu producer r3", 0, 0, 0); end
        1: begin set_id(1, 0, 0, 5'd0, 5'd3, 5'd9, 2'b11); sb_push("alu consumer in ID", 0, 0, 0); end
        2: begin set_id(1, 0, 0, 5'd0, 5'd0, 5'd0, 2'b00); sb_push("alu consumer in EX", 0, 1, 0); end
        3: begin set_id(1, 0, 0, 5'd0, 5'd0, 5'd3, 2'b10); sb_push("alu filler in EX", 0, 0, 0); end
        default: begin set_id(0, 0, 0, 0, 0, 0, 2'b00); sb_push("alu late reader", 0, 0, 0); end
      endcase
      @(negedge clk);
      e = sbq.pop_front();
      $display("[%0t] %s: stall=%b sel0=%0d sel1=%0d", $time, e.tag, stall, ex_fwd_sel[1:0], ex_fwd_sel[3:2]);
      nAsserts++;
      if (stall !== e.st) begin nFails++; $display("FAIL %s stall: got %b expected %b", e.tag, stall, e.st); end
      nAsserts++;
      if (ex_fwd_sel[1:0] !== e.s0) begin nFails++; $display("FAIL %s sel0: got %0d expected %0d", e.tag, ex_fwd_sel[1:0], e.s0); end
      nAsserts++;
      if (ex_fwd_sel[3:2] !== e.s1) begin nFails++; $display("FAIL %s sel1: got %0d expected %0d", e.tag, ex_fwd_sel[3:2], e.s1); end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_load_use();
    exp_t e;
    for (int c = 0; c < 5; c++) begin
      case (c)
        0: begin set_id(1, 1, 1, 5'd5, 5'd0, 5'd0, 2'b00); sb_push("load r5", 0, 0, 0); end
        1: begin set_id(1, 0, 0, 5'd0, 5'd5, 5'd6, 2'b11); sb_push("load-use stall", 1, 0, 0); end
        2: begin set_id(1, 0, 0, 5'd0, 5'd5, 5'd6, 2'b11); sb_push("load-use released", 0, 0, 0); end
        3: begin set_id(0, 0, 0, 0, 0, 0, 2'b00); sb_push("load fwd from stage 2", 0, 2, 0); end
        default: begin set_id(0, 0, 0, 0, 0, 0, 2'b00); sb_push("load tail", 0, 0, 0); end
      endcase
      @(negedge clk);
      e = sbq.pop_front();
      $display("[%0t] %s: stall=%b sel0=%0d sel1=%0d", $time, e.tag, stall, ex_fwd_sel[1:0], ex_fwd_sel[3:2]);
      nAsserts++;
      if (stall !== e.st) begin nFails++; $display("FAIL %s stall: got %b expected %b", e.tag, stall, e.st); end
      nAsserts++;
      if (ex_fwd_sel[1:0] !== e.s0) begin nFails++; $display("FAIL %s sel0: got %0d expected %0d", e.tag, ex_fwd_sel[1:0], e.s0); end
      nAsserts++;
      if (ex_fwd_sel[3:2] !== e.s1) begin nFails++; $display("FAIL %s sel1: got %0d expected %0d", e.tag, ex_fwd_sel[3:2], e.s1); end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int c = 0; c < 5; c++) begin
      case (c)
        0: begin set_id(1, 1, 0, 5'd7, 5'd0, 5'd0, 2'b00); sb_push("b2b older r7", 0, 0, 0); end
        1: begin set_id(1, 1, 0, 5'd7, 5'd0, 5'd0, 2'b00); sb_push("b2b younger r7", 0, 0, 0); end
        2: begin set_id(1, 0, 0, 5'd0, 5'd2, 5'd7, 2'b11); sb_push("b2b consumer in ID", 0, 0, 0); end
        3: begin set_id(1, 0, 0, 5'd0, 5'd7, 5'd0, 2'b01); sb_push("b2b youngest wins", 0, 0, 1); end
        default: begin set_id(0, 0, 0, 0, 0, 0, 2'b00); sb_push("b2b stage 2 alu", 0, 2, 0); end
      endcase
      @(negedge clk);
      e = sbq.pop_front();
      $display("[%0t] %s: stall=%b sel0=%0d sel1=%0d", $time, e.tag, stall, ex_fwd_sel[1:0], ex_fwd_sel[3:2]);
      nAsserts++;
      if (stall !== e.st) begin nFails++; $display("FAIL %s stall: got %b expected %b", e.tag, stall, e.st); end
      nAsserts++;
      if (ex_fwd_sel[1:0] !== e.s0) begin nFails++; $display("FAIL %s sel0: got %0d expected %0d", e.tag, ex_fwd_sel[1:0], e.s0); end
      nAsserts++;
      if (ex_fwd_sel[3:2] !== e.s1) begin nFails++; $display("FAIL %s sel1: got %0d expected %0d", e.tag, ex_fwd_sel[3:2], e.s1); end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_r0_and_gating();
    exp_t e;
    for (int c = 0; c < 6; c++) begin
      case (c)
        0: begin set_id(1, 1, 0, 5'd0, 5'd0, 5'd0, 2'b00); sb_push("r0 alu writer", 0, 0, 0); end
        1: begin set_id(1, 1, 1, 5'd0, 5'd0, 5'd0, 2'b01); sb_push("r0 load writer", 0, 0, 0); end
        2: begin set_id(1, 0, 0, 5'd0, 5'd0, 5'd0, 2'b11); sb_push("r0 no stall", 0, 0, 0); end
        3: begin set_id(1, 1, 1, 5'd5, 5'd0, 5'd0, 2'b00); sb_push("r0 no fwd", 0, 0, 0); end
        4: begin set_id(0, 0, 0, 5'd0, 5'd5, 5'd5, 2'b11); sb_push("invalid ID no stall", 0, 0, 0); end
        default: begin set_id(0, 0, 0, 0, 0, 0, 2'b00); sb_push("gating tail", 0, 0, 0); end
      endcase
      @(negedge clk);
      e = sbq.pop_front();
      $display("[%0t] %s: stall=%b sel0=%0d sel1=%0d", $time, e.tag, stall, ex_fwd_sel[1:0], ex_fwd_sel[3:2]);
      nAsserts++;
      if (stall !== e.st) begin nFails++; $display("FAIL %s stall: got %b expected %b", e.tag, stall, e.st); end
      nAsserts++;
      if (ex_fwd_sel[1:0] !== e.s0) begin nFails++; $display("FAIL %s sel0: got %0d expected %0d", e.tag, ex_fwd_sel[1:0], e.s0); end
      nAsserts++;
      if (ex_fwd_sel[3:2] !== e.s1) begin nFails++; $display("FAIL %s sel1: got %0d expected %0d", e.tag, ex_fwd_sel[3:2], e.s1); end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_flush();
    exp_t e;
    for (int c = 0; c < 4; c++) begin
      case (c)
        0: begin flush = 0; set_id(1, 1, 1, 5'd5, 5'd0, 5'd0, 2'b00); sb_push("flush load r5", 0, 0, 0); end
        1: begin flush = 1; set_id(1, 0, 0, 5'd0, 5'd5, 5'd0, 2'b01); sb_push("flush beats stall", 0, 0, 0); end
        2: begin flush = 0; set_id(1, 0, 0, 5'd0, 5'd5, 5'd0, 2'b01); sb_push("flush EX/MEM killed", 0, 0, 0); end
        default: begin flush = 0; set_id(0, 0, 0, 0, 0, 0, 2'b00); sb_push("flush no fwd r5", 0, 0, 0); end
      endcase
      @(negedge clk);
      e = sbq.pop_front();
      $display("[%0t] %s: stall=%b sel0=%0d sel1=%0d", $time, e.tag, stall, ex_fwd_sel[1:0], ex_fwd_sel[3:2]);
      nAsserts++;
      if (stall !== e.st) begin nFails++; $display("FAIL %s stall: got %b expected %b", e.tag, stall, e.st); end
      nAsserts++;
      if (ex_fwd_sel[1:0] !== e.s0) begin nFails++; $display("FAIL %s sel0: got %0d expected %0d", e.tag, ex_fwd_sel[1:0], e.s0); end
      nAsserts++;
      if (ex_fwd_sel[3:2] !== e.s1) begin nFails++; $display("FAIL %s sel1: got %0d expected %0d", e.tag, ex_fwd_sel[3:2], e.s1); end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset_during_hold();
    exp_t e;
    // Build a held load-use stall with a live forward on operand 1.
    for (int c = 0; c < 4; c++) begin
      case (c)
        0: begin set_id(1, 1, 0, 5'd6, 5'd0, 5'd0, 2'b00); sb_push("hold alu r6", 0, 0, 0); end
        1: begin set_id(1, 1, 1, 5'd5, 5'd0, 5'd6, 2'b10); sb_push("hold load r5", 0, 0, 0); end
        2: begin pipe_hold = 1; set_id(1, 0, 0, 5'd0, 5'd5, 5'd6, 2'b11); sb_push("hold stall", 1, 0, 1); end
        default: begin pipe_hold = 1; sb_push("hold frozen", 1, 0, 1); end
      endcase
      @(negedge clk);
      e = sbq.pop_front();
      $display("[%0t] %s: stall=%b sel0=%0d sel1=%0d", $time, e.tag, stall, ex_fwd_sel[1:0], ex_fwd_sel[3:2]);
      nAsserts++;
      if (stall !== e.st) begin nFails++; $display("FAIL %s stall: got %b expected %b", e.tag, stall, e.st); end
      nAsserts++;
      if (ex_fwd_sel[1:0] !== e.s0) begin nFails++; $display("FAIL %s sel0: got %0d expected %0d", e.tag, ex_fwd_sel[1:0], e.s0); end
      nAsserts++;
      if (ex_fwd_sel[3:2] !== e.s1) begin nFails++; $display("FAIL %s sel1: got %0d expected %0d", e.tag, ex_fwd_sel[3:2], e.s1); end
      @(posedge clk);
      #1;
    end
    // Asynchronous reset between clock edges must clear outputs at once.
    #1;
    rst = 1'b1;
    sb_push("async reset mid-stall", 0, 0, 0);
    #1;
    e = sbq.pop_front();
    $display("[%0t] %s: stall=%b sel0=%0d sel1=%0d", $time, e.tag, stall, ex_fwd_sel[1:0], ex_fwd_sel[3:2]);
    nAsserts++;
    if (stall !== e.st) begin nFails++; $display("FAIL %s stall: got %b expected %b", e.tag, stall, e.st); end
    nAsserts++;
    if (ex_fwd_sel[1:0] !== e.s0) begin nFails++; $display("FAIL %s sel0: got %0d expected %0d", e.tag, ex_fwd_sel[1:0], e.s0); end
    nAsserts++;
    if (ex_fwd_sel[3:2] !== e.s1) begin nFails++; $display("FAIL %s sel1: got %0d expected %0d", e.tag, ex_fwd_sel[3:2], e.s1); end
    #1;
    rst       = 1'b0;
    pipe_hold = 1'b0;
    // After release, nothing forwards until a new writer has entered.
    for (int c = 0; c < 4; c++) begin
      case (c)
        0: begin set_id(1, 0, 0, 5'd0, 5'd5, 5'd6, 2'b11); sb_push("post-reset consumer", 0, 0, 0); end
        1: begin set_id(1, 1, 0, 5'd6, 5'd0, 5'd0, 2'b00); sb_push("post-reset empty", 0, 0, 0); end
        2: begin set_id(1, 0, 0, 5'd0, 5'd6, 5'd0, 2'b01); sb_push("post-reset reader", 0, 0, 0); end
        default: begin set_id(0, 0, 0, 0, 0, 0, 2'b00); sb_push("post-reset new fwd", 0, 1, 0); end
      endcase
      @(negedge clk);
      e = sbq.pop_front();
      $display("[%0t] %s: stall=%b sel0=%0d sel1=%0d", $time, e.tag, stall, ex_fwd_sel[1:0], ex_fwd_sel[3:2]);
      nAsserts++;
      if (stall !== e.st) begin nFails++; $display("FAIL %s stall: got %b expected %b", e.tag, stall, e.st); end
      nAsserts++;
      if (ex_fwd_sel[1:0] !== e.s0) begin nFails++; $display("FAIL %s sel0: got %0d expected %0d", e.tag, ex_fwd_sel[1:0], e.s0); end
      nAsserts++;
      if (ex_fwd_sel[3:2] !== e.s1) begin nFails++; $display("FAIL %s sel1: got %0d expected %0d", e.tag, ex_fwd_sel[3:2], e.s1); end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_alu_fwd();
    drain();
    test_load_use();
    drain();
    test_back_to_back();
    drain();
    test_r0_and_gating();
    drain();
    test_flush();
    drain();
    test_reset_during_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
